// File: rtl/cop0_state_unit.sv
// rtl/cop0_state_unit.sv - CP0 register state: Count/Compare timer, Status/Cause, EPC, EBase, exception entry and ERET.
// Read port is combinational; all state updates happen on the rising clock edge.
module cop0_state_unit #(
  parameter int          COUNT_DIV    = 2,
  parameter int          NUM_HW_INT   = 5,
  parameter logic [31:0] EBASE_RESET  = 32'h80000000,
  parameter logic [31:0] STATUS_RESET = 32'h00400004
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [4:0]            write_rd,
  input  logic [2:0]            write_sel,
  input  logic [31:0]           din,
  input  logic [4:0]            read_rd,
  input  logic [2:0]            read_sel,
  output logic [31:0]           dout,
  input  logic [NUM_HW_INT-1:0] hw_int,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic [31:0]           exc_pc,
  input  logic                  exc_bd,
  input  logic                  exc_badvaddr_valid,
  input  logic [31:0]           exc_badvaddr,
  input  logic                  eret,
  output logic                  int_pending,
  output logic [31:0]           exc_vector,
  output logic [31:0]           epc_out
);
  localparam logic [31:0] STATUS_WMASK = 32'h0040FF07;
  localparam logic [4:0]  PRESC_MAX    = 5'(COUNT_DIV - 1);

  logic [31:0]           r_count;
  logic [31:0]           r_compare;
  logic [31:0]           r_status;
  logic [29:12]          r_ebase;
  logic [31:0]           r_epc;
  logic [31:0]           r_badvaddr;
  logic [4:0]            r_presc;
  logic                  r_bd;
  logic                  r_ti;
  logic [1:0]            r_ip_sw;
  logic [NUM_HW_INT-1:0] r_ip_hw;
  logic [4:0]            r_exc_code;

  logic        w_exl, w_erl, w_ie, w_bev;
  logic        w_take_we, w_tick, w_match;
  logic        w_wr_count, w_wr_compare, w_wr_status, w_wr_cause, w_wr_epc, w_wr_ebase;
  logic [31:0] w_count_next;
  logic [4:0]  w_presc_next;
  logic [4:0]  w_hw_pad;
  logic [7:0]  w_ip;
  logic [31:0] w_cause;
  logic [31:0] w_ebase_rd;

  assign w_ie  = r_status[0];
  assign w_exl = r_status[1];
  assign w_erl = r_status[2];
  assign w_bev = r_status[22];

  // Software writes lose to both an exception and an ERET in the same cycle.
  assign w_take_we    = we & ~exc_valid & ~eret;
  assign w_wr_count   = w_take_we && write_rd == 5'd9  && write_sel == 3'd0;
  assign w_wr_compare = w_take_we && write_rd == 5'd11 && write_sel == 3'd0;
  assign w_wr_status  = w_take_we && write_rd == 5'd12 && write_sel == 3'd0;
  assign w_wr_cause   = w_take_we && write_rd == 5'd13 && write_sel == 3'd0;
  assign w_wr_epc     = w_take_we && write_rd == 5'd14 && write_sel == 3'd0;
  assign w_wr_ebase   = w_take_we && write_rd == 5'd15 && write_sel == 3'd1;

  assign w_tick       = (r_presc == PRESC_MAX);
  assign w_count_next = w_wr_count ? din : (w_tick ? r_count + 32'd1 : r_count);
  assign w_presc_next = (w_wr_count || w_tick) ? 5'd0 : r_presc + 5'd1;
  assign w_match      = (w_count_next != r_count) && (w_count_next == r_compare);

  always_comb begin
    w_hw_pad                 = '0;
    w_hw_pad[NUM_HW_INT-1:0] = r_ip_hw;
  end

  assign w_ip       = {r_ti, w_hw_pad, r_ip_sw};
  assign w_cause    = {r_bd, r_ti, 14'h0, w_ip, 1'b0, r_exc_code, 2'b00};
  assign w_ebase_rd = {2'b10, r_ebase, 12'h000};

  always_comb begin
    dout = 32'h0;
    case ({read_rd, read_sel})
      {5'd8,  3'd0}: dout = r_badvaddr;
      {5'd9,  3'd0}: dout = r_count;
      {5'd11, 3'd0}: dout = r_compare;
      {5'd12, 3'd0}: dout = r_status;
      {5'd13, 3'd0}: dout = w_cause;
      {5'd14, 3'd0}: dout = r_epc;
      {5'd15, 3'd1}: dout = w_ebase_rd;
      default:       dout = 32'h0;
    endcase
  end

  assign int_pending = w_ie & ~w_exl & ~w_erl & (|(w_ip & r_status[15:8]));
  assign exc_vector  = w_bev ? 32'hBFC00380 : {w_ebase_rd[31:12], 12'h180};
  assign epc_out     = r_epc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= 32'h0;
      r_presc    <= 5'd0;
      r_compare  <= 32'hFFFFFFFF;
      r_status   <= STATUS_RESET;
      r_ebase    <= EBASE_RESET[29:12];
      r_epc      <= 32'h0;
      r_badvaddr <= 32'h0;
      r_bd       <= 1'b0;
      r_ti       <= 1'b0;
      r_ip_sw    <= 2'b00;
      r_ip_hw    <= '0;
      r_exc_code <= 5'd0;
    end else begin
      r_count <= w_count_next;
      r_presc <= w_presc_next;
      r_ip_hw <= hw_int;

      // A Compare write clears TI even when a match lands in the same cycle.
      if (w_wr_compare) begin
        r_compare <= din;
        r_ti      <= 1'b0;
      end else if (w_match) begin
        r_ti <= 1'b1;
      end

      if (exc_valid) begin
        if (!w_exl) begin
          r_epc <= exc_bd ? exc_pc - 32'd4 : exc_pc;
          r_bd  <= exc_bd;
        end
        r_exc_code  <= exc_code;
        r_status[1] <= 1'b1;
        if (exc_badvaddr_valid) r_badvaddr <= exc_badvaddr;
      end else if (eret) begin
        if (w_erl) r_status[2] <= 1'b0;
        else       r_status[1] <= 1'b0;
      end else begin
        if (w_wr_status) r_status <= (r_status & ~STATUS_WMASK) | (din & STATUS_WMASK);
        if (w_wr_cause)  r_ip_sw  <= din[9:8];
        if (w_wr_epc)    r_epc    <= din;
        if (w_wr_ebase)  r_ebase  <= din[29:12];
      end
    end
  end
endmodule

// File: tb/tb_cop0_state_unit.sv
// tb/tb_cop0_state_unit.sv - self-checking bench for cop0_state_unit.
// Table-driven register vectors, directed timer/exception sequences, then random traffic against a model.
module tb_cop0_state_unit;
  localparam int COUNT_DIV  = 2;
  localparam int NUM_HW_INT = 5;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  we = 1'b0;
  logic [4:0]            write_rd = '0;
  logic [2:0]            write_sel = '0;
  logic [31:0]           din = '0;
  logic [4:0]            read_rd = '0;
  logic [2:0]            read_sel = '0;
  logic [31:0]           dout;
  logic [NUM_HW_INT-1:0] hw_int = '0;
  logic                  exc_valid = 1'b0;
  logic [4:0]            exc_code = '0;
  logic [31:0]           exc_pc = '0;
  logic                  exc_bd = 1'b0;
  logic                  exc_badvaddr_valid = 1'b0;
  logic [31:0]           exc_badvaddr = '0;
  logic                  eret = 1'b0;
  logic                  int_pending;
  logic [31:0]           exc_vector;
  logic [31:0]           epc_out;

  int n_checks = 0;
  int n_errors = 0;

  cop0_state_unit #(.COUNT_DIV(COUNT_DIV), .NUM_HW_INT(NUM_HW_INT)) dut (
    .clk(clk), .reset(reset), .we(we), .write_rd(write_rd), .write_sel(write_sel),
    .din(din), .read_rd(read_rd), .read_sel(read_sel), .dout(dout), .hw_int(hw_int),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_badvaddr_valid(exc_badvaddr_valid), .exc_badvaddr(exc_badvaddr), .eret(eret),
    .int_pending(int_pending), .exc_vector(exc_vector), .epc_out(epc_out)
  );

  always #50 clk = ~clk;

  // Reference model state, kept as architectural fields.
  logic [31:0] m_count, m_compare, m_status, m_ebase, m_epc, m_badv;
  int          m_phase;
  logic        m_bd, m_ti;
  logic [1:0]  m_swip;
  logic [4:0]  m_hw, m_exc;

  function automatic logic [31:0] m_cause();
    return {m_bd, m_ti, 14'h0, m_ti, m_hw, m_swip, 1'b0, m_exc, 2'b00};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] rd, input logic [2:0] sel);
    if (rd == 8  && sel == 0) return m_badv;
    if (rd == 9  && sel == 0) return m_count;
    if (rd == 11 && sel == 0) return m_compare;
    if (rd == 12 && sel == 0) return m_status;
    if (rd == 13 && sel == 0) return m_cause();
    if (rd == 14 && sel == 0) return m_epc;
    if (rd == 15 && sel == 1) return m_ebase;
    return 32'h0;
  endfunction

  function automatic logic m_int();
    logic [31:0] c;
    logic        any;
    c   = m_cause();
    any = 1'b0;
    for (int i = 0; i < 8; i++)
      if (c[8+i] && m_status[8+i]) any = 1'b1;
    return m_status[0] && !m_status[1] && !m_status[2] && any;
  endfunction

  function automatic logic [31:0] m_vector();
    if (m_status[22]) return 32'hBFC00380;
    return {m_ebase[31:12], 12'h180};
  endfunction

  task automatic m_reset();
    m_count = 0; m_phase = 0; m_compare = 32'hFFFFFFFF; m_status = 32'h00400004;
    m_ebase = 32'h80000000; m_epc = 0; m_badv = 0; m_bd = 0; m_ti = 0; m_swip = 0;
    m_hw = 0; m_exc = 0;
  endtask

  task automatic m_step();
    logic [31:0] n_count;
    int          n_phase;
    logic        wr;
    if (reset) begin
      m_reset();
      return;
    end
    wr      = we && !exc_valid && !eret;
    n_phase = m_phase + 1;
    n_count = (n_phase % COUNT_DIV == 0) ? m_count + 1 : m_count;
    if (wr && write_rd == 9 && write_sel == 0) begin
      n_count = din;
      n_phase = 0;
    end
    if (n_count != m_count && n_count == m_compare) m_ti = 1;
    if (wr && write_rd == 11 && write_sel == 0) begin
      m_compare = din;
      m_ti      = 0;
    end
    m_count = n_count;
    m_phase = n_phase;
    m_hw    = hw_int;
    if (exc_valid) begin
      if (!m_status[1]) begin
        m_epc = exc_bd ? exc_pc - 4 : exc_pc;
        m_bd  = exc_bd;
      end
      m_exc       = exc_code;
      m_status[1] = 1;
      if (exc_badvaddr_valid) m_badv = exc_badvaddr;
    end else if (eret) begin
      if (m_status[2]) m_status[2] = 0;
      else             m_status[1] = 0;
    end else if (wr) begin
      if (write_rd == 12 && write_sel == 0)
        m_status = (m_status & ~32'h0040FF07) | (din & 32'h0040FF07);
      if (write_rd == 13 && write_sel == 0) m_swip = din[9:8];
      if (write_rd == 14 && write_sel == 0) m_epc = din;
      if (write_rd == 15 && write_sel == 1) m_ebase = {2'b10, din[29:12], 12'h000};
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all();
    chk("dout", dout, m_read(read_rd, read_sel));
    chk("int_pending", {31'h0, int_pending}, {31'h0, m_int()});
    chk("exc_vector", exc_vector, m_vector());
    chk("epc_out", epc_out, m_epc);
  endtask

  task automatic cycle();
    m_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic rd_chk(input string name, input logic [4:0] rd, input logic [2:0] sel,
                        input logic [31:0] exp);
    read_rd  = rd;
    read_sel = sel;
    #1;
    chk(name, dout, exp);
  endtask

  task automatic wr_reg(input logic [4:0] rd, input logic [2:0] sel, input logic [31:0] d);
    we = 1; write_rd = rd; write_sel = sel; din = d;
    cycle();
    we = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    cycle();
    reset = 0;
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic [2:0]  sel;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [4:0] rd_pick[9];
    m_reset();

    vecs.push_back('{5'd12, 3'd0, 32'hFFFFFFFF, 32'h0040FF07, "status_ones"});
    vecs.push_back('{5'd12, 3'd0, 32'h00000000, 32'h00000000, "status_zero"});
    vecs.push_back('{5'd15, 3'd1, 32'hFFFFFFFF, 32'hBFFFF000, "ebase_ones"});
    vecs.push_back('{5'd15, 3'd1, 32'h00000000, 32'h80000000, "ebase_zero"});
    vecs.push_back('{5'd13, 3'd0, 32'hFFFFFFFF, 32'h00000300, "cause_ones"});
    vecs.push_back('{5'd13, 3'd0, 32'h00000000, 32'h00000000, "cause_zero"});
    vecs.push_back('{5'd8,  3'd0, 32'hFFFFFFFF, 32'h00000000, "badv_ro"});
    vecs.push_back('{5'd14, 3'd0, 32'h12345678, 32'h12345678, "epc_rw"});
    vecs.push_back('{5'd11, 3'd0, 32'hAAAA5555, 32'hAAAA5555, "compare_rw"});
    vecs.push_back('{5'd10, 3'd0, 32'h00001234, 32'h00000000, "unimpl_10"});
    vecs.push_back('{5'd15, 3'd0, 32'hDEADBEEF, 32'h00000000, "unimpl_15_0"});

    repeat (2) cycle();
    do_reset();
    rd_chk("rst_badv",    5'd8,  3'd0, 32'h0);
    rd_chk("rst_count",   5'd9,  3'd0, 32'h0);
    rd_chk("rst_compare", 5'd11, 3'd0, 32'hFFFFFFFF);
    rd_chk("rst_status",  5'd12, 3'd0, 32'h00400004);
    rd_chk("rst_cause",   5'd13, 3'd0, 32'h0);
    rd_chk("rst_epc",     5'd14, 3'd0, 32'h0);
    rd_chk("rst_ebase",   5'd15, 3'd1, 32'h80000000);
    rd_chk("rst_unimpl",  5'd10, 3'd0, 32'h0);
    chk("rst_vector", exc_vector, 32'hBFC00380);
    chk("rst_int", {31'h0, int_pending}, 32'h0);

    foreach (vecs[i]) begin
      wr_reg(vecs[i].rd, vecs[i].sel, vecs[i].wdata);
      rd_chk(vecs[i].name, vecs[i].rd, vecs[i].sel, vecs[i].exp);
    end

    // Timer wrap and Compare match.
    do_reset();
    wr_reg(5'd12, 3'd0, 32'h00008001);
    wr_reg(5'd11, 3'd0, 32'h00000000);
    wr_reg(5'd9,  3'd0, 32'hFFFFFFFE);
    repeat (3) cycle();
    rd_chk("tmr_cnt3", 5'd9, 3'd0, 32'hFFFFFFFF);
    rd_chk("tmr_ti3",  5'd13, 3'd0, 32'h0);
    cycle();
    rd_chk("tmr_cnt4", 5'd9, 3'd0, 32'h0);
    rd_chk("tmr_ti4",  5'd13, 3'd0, 32'h40008000);
    chk("tmr_int", {31'h0, int_pending}, 32'h1);
    wr_reg(5'd11, 3'd0, 32'h00000100);
    rd_chk("tmr_ticlr", 5'd13, 3'd0, 32'h0);
    chk("tmr_intclr", {31'h0, int_pending}, 32'h0);

    // Exception entry and nested exception.
    do_reset();
    wr_reg(5'd12, 3'd0, 32'h0);
    exc_valid = 1; exc_pc = 32'h80001004; exc_bd = 1; exc_code = 5'h04;
    exc_badvaddr_valid = 1; exc_badvaddr = 32'h00000003;
    cycle();
    exc_pc = 32'h90000000; exc_bd = 0; exc_code = 5'h05; exc_badvaddr_valid = 0;
    rd_chk("exc_epc",    5'd14, 3'd0, 32'h80001000);
    rd_chk("exc_cause",  5'd13, 3'd0, 32'h80000010);
    rd_chk("exc_status", 5'd12, 3'd0, 32'h00000002);
    rd_chk("exc_badv",   5'd8,  3'd0, 32'h00000003);
    cycle();
    exc_valid = 0;
    rd_chk("exc2_epc",   5'd14, 3'd0, 32'h80001000);
    rd_chk("exc2_cause", 5'd13, 3'd0, 32'h80000014);
    rd_chk("exc2_badv",  5'd8,  3'd0, 32'h00000003);

    // Exception beats ERET and a Status write in the same cycle.
    do_reset();
    wr_reg(5'd12, 3'd0, 32'h0);
    exc_valid = 1; eret = 1; exc_pc = 32'h80002000; exc_bd = 0; exc_code = 5'h0C;
    we = 1; write_rd = 5'd12; write_sel = 3'd0; din = 32'hFFFFFFFF;
    cycle();
    exc_valid = 0; eret = 0; we = 0;
    rd_chk("prio_status", 5'd12, 3'd0, 32'h00000002);
    rd_chk("prio_epc",    5'd14, 3'd0, 32'h80002000);

    // ERET clears ERL first, then EXL.
    do_reset();
    exc_valid = 1; exc_pc = 32'h80003000; exc_code = 5'h08;
    cycle();
    exc_valid = 0;
    rd_chk("eret_pre", 5'd12, 3'd0, 32'h00400006);
    eret = 1;
    cycle();
    rd_chk("eret_erl", 5'd12, 3'd0, 32'h00400002);
    cycle();
    eret = 0;
    rd_chk("eret_exl", 5'd12, 3'd0, 32'h00400000);

    // Random traffic checked every cycle against the model.
    rd_pick = '{5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0};
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 299) == 0);
      we        = ($urandom_range(0, 2) == 0);
      write_rd  = rd_pick[$urandom_range(0, 8)];
      if (write_rd == 5'd0) write_rd = 5'($urandom);
      write_sel = (write_rd == 5'd15) ? 3'($urandom_range(0, 1)) : 3'(($urandom_range(0, 9) == 0) ? 2 : 0);
      din       = $urandom;
      if (write_rd == 5'd11 && $urandom_range(0, 1) == 1) din = m_count + $urandom_range(0, 6);
      if (write_rd == 5'd9  && $urandom_range(0, 1) == 1) din = m_compare - $urandom_range(0, 6);
      if (write_rd == 5'd12 && $urandom_range(0, 1) == 1) din = $urandom & 32'hFFBFFFF9;
      read_rd   = rd_pick[$urandom_range(0, 8)];
      read_sel  = (read_rd == 5'd15) ? 3'($urandom_range(0, 1)) : 3'd0;
      hw_int    = NUM_HW_INT'($urandom);
      exc_valid = ($urandom_range(0, 11) == 0);
      eret      = ($urandom_range(0, 9) == 0);
      exc_code  = 5'($urandom);
      exc_pc    = $urandom;
      exc_bd    = 1'($urandom);
      exc_badvaddr_valid = 1'($urandom);
      exc_badvaddr       = $urandom;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
